// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the BCD display path.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam seg7_t SEG_MINUS = 7'h3F;  // segment g only
  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_ERR   = 7'h06;  // "E": a,d,e,f,g

endpackage

// File: rtl/bcd_display_mux_if.sv
// Bus between the BCD source and the display multiplexer.
//   load/bcd/is_negative/blank_lz : source -> display
//   an_n/seg_n/dp_n               : display -> board pins (active-low)
interface bcd_display_mux_if #(
  parameter int BCD_DIGITS = 5,
  parameter int NUM_ANODES = 8
);
  import seg7_pkg::*;

  logic                    load;
  logic [BCD_DIGITS*4-1:0] bcd;
  logic                    is_negative;
  logic                    blank_lz;
  logic [NUM_ANODES-1:0]   an_n;
  seg7_t                   seg_n;
  logic                    dp_n;

  modport master (
    output load, bcd, is_negative, blank_lz,
    input  an_n, seg_n, dp_n
  );

  modport slave (
    input  load, bcd, is_negative, blank_lz,
    output an_n, seg_n, dp_n
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
//   i_nibble : BCD digit; values above 9 show "E"
//   o_seg_n  : {g,f,e,d,c,b,a}, active-low
module bcd_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg7_t      o_seg_n
);

  always_comb begin
    o_seg_n = SEG_ERR;
    case (i_nibble)
      4'd0: o_seg_n = SEG_DIGIT[0];
      4'd1: o_seg_n = SEG_DIGIT[1];
      4'd2: o_seg_n = SEG_DIGIT[2];
      4'd3: o_seg_n = SEG_DIGIT[3];
      4'd4: o_seg_n = SEG_DIGIT[4];
      4'd5: o_seg_n = SEG_DIGIT[5];
      4'd6: o_seg_n = SEG_DIGIT[6];
      4'd7: o_seg_n = SEG_DIGIT[7];
      4'd8: o_seg_n = SEG_DIGIT[8];
      4'd9: o_seg_n = SEG_DIGIT[9];
      default: o_seg_n = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed common-anode display driver for a signed BCD value.
//   clk, reset : system clock, synchronous active-high reset
//   bus.load / bcd / is_negative : capture strobe and captured value
//   bus.blank_lz : live leading-zero blanking select
//   bus.an_n / seg_n / dp_n : registered active-low display outputs
module bcd_display_mux
  import seg7_pkg::*;
#(
  parameter int BCD_DIGITS = 5,
  parameter int NUM_ANODES = 8,
  parameter int TICK_DIV   = 100000
) (
  input  logic               clk,
  input  logic               reset,
  bcd_display_mux_if.slave   bus
);

  localparam int IDX_W = (NUM_ANODES > 1) ? $clog2(NUM_ANODES) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (NUM_ANODES < BCD_DIGITS + 1) begin : g_bad_anodes
    $error("NUM_ANODES must be at least BCD_DIGITS+1");
  end
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("TICK_DIV must be at least 2");
  end

  logic [PRE_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [3:0]            r_digits [BCD_DIGITS];
  logic                  r_neg;
  logic [NUM_ANODES-1:0] r_an_n;
  seg7_t                 r_seg_n;

  logic [IDX_W-1:0]      w_msd;
  logic                  w_nonzero;
  logic [IDX_W-1:0]      w_minus_pos;
  logic [3:0]            w_nibble;
  seg7_t                 w_dec;
  seg7_t                 w_seg_n;
  logic [NUM_ANODES-1:0] w_an_n;

  // Prescaler and scan index
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRE_W'(TICK_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_W'(NUM_ANODES - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // Capture registers; reset wins over load
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < BCD_DIGITS; k++) r_digits[k] <= '0;
      r_neg <= 1'b0;
    end else if (bus.load) begin
      for (int unsigned k = 0; k < BCD_DIGITS; k++) r_digits[k] <= bus.bcd[k*4 +: 4];
      r_neg <= bus.is_negative;
    end
  end

  // Most-significant nonzero digit; invalid nibbles count as nonzero
  always_comb begin
    w_msd     = '0;
    w_nonzero = 1'b0;
    for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
      if (r_digits[k] != 4'd0) begin
        w_msd     = IDX_W'(k);
        w_nonzero = 1'b1;
      end
    end
  end

  assign w_minus_pos = bus.blank_lz ? (w_msd + IDX_W'(1)) : IDX_W'(BCD_DIGITS);

  always_comb begin
    w_nibble = '0;
    for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) w_nibble = r_digits[k];
    end
  end

  bcd_to_7seg u_dec (
    .i_nibble (w_nibble),
    .o_seg_n  (w_dec)
  );

  // The minus test comes first: with blanking on it lands on a slot that
  // would otherwise be a blanked leading zero. A zero value never gets one.
  always_comb begin
    w_seg_n = SEG_BLANK;
    if (r_neg && w_nonzero && (r_idx == w_minus_pos)) begin
      w_seg_n = SEG_MINUS;
    end else if ((r_idx < IDX_W'(BCD_DIGITS)) && ((r_idx <= w_msd) || !bus.blank_lz)) begin
      w_seg_n = w_dec;
    end
  end

  always_comb begin
    w_an_n        = '1;
    w_an_n[r_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_n  <= '1;
      r_seg_n <= SEG_BLANK;
    end else begin
      r_an_n  <= w_an_n;
      r_seg_n <= w_seg_n;
    end
  end

  assign bus.an_n  = r_an_n;
  assign bus.seg_n = r_seg_n;
  assign bus.dp_n  = 1'b1;

endmodule

// File: tb/tb_bcd_display_mux.sv
module tb_bcd_display_mux;

  localparam int BD = 5;
  localparam int NA = 8;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_display_mux_if #(.BCD_DIGITS(BD), .NUM_ANODES(NA)) bus ();

  bcd_display_mux #(
    .BCD_DIGITS (BD),
    .NUM_ANODES (NA),
    .TICK_DIV   (TD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_cnt;
  logic [19:0] m_val;
  logic        m_neg;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  int          exp_slot;

  // Table-driven expectations, slot 0 in bits [6:0]
  typedef struct {
    logic [19:0] bcd;
    logic        neg;
    logic        blz;
    logic [55:0] segs;
  } vec_t;

  vec_t        vecs [10];
  logic [55:0] tbl_segs;
  bit          tbl_on = 1'b0;

  function automatic logic [6:0] ref_glyph(int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h06;
    endcase
  endfunction

  // Display rule: digits up to the top significant one, padding zeros only
  // when blanking is off, a minus just left of the number, never for zero.
  function automatic logic [6:0] ref_seg(int slot, logic [19:0] v, logic neg, logic blz);
    int dig [BD];
    int top;
    bit nz;
    int mpos;
    top = 0;
    nz  = 1'b0;
    for (int i = 0; i < BD; i++) begin
      dig[i] = int'(v[i*4 +: 4]);
      if (dig[i] != 0) begin
        top = i;
        nz  = 1'b1;
      end
    end
    mpos = blz ? top + 1 : BD;
    if (neg && nz && slot == mpos) return 7'h3F;
    if (slot < BD && (slot <= top || !blz)) return ref_glyph(dig[slot]);
    return 7'h7F;
  endfunction

  task automatic step_model();
    if (reset) begin
      m_cnt    = 0;
      m_val    = '0;
      m_neg    = 1'b0;
      exp_an   = 8'hFF;
      exp_seg  = 7'h7F;
      exp_slot = -1;
    end else begin
      exp_slot = (m_cnt / TD) % NA;
      exp_an   = ~(8'd1 << exp_slot);
      exp_seg  = ref_seg(exp_slot, m_val, m_neg, bus.blank_lz);
      m_cnt++;
      if (bus.load) begin
        m_val = bus.bcd;
        m_neg = bus.is_negative;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step_model();
    #1;
    check("an_n", 32'(bus.an_n), 32'(exp_an));
    check("seg_n", 32'(bus.seg_n), 32'(exp_seg));
    check("dp_n", 32'(bus.dp_n), 32'd1);
    if (tbl_on && exp_slot >= 0)
      check("table_seg", 32'(bus.seg_n), 32'(tbl_segs[exp_slot*7 +: 7]));
  endtask

  initial begin
    vecs[0] = '{20'h00123, 1'b0, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h24,7'h30}};
    vecs[1] = '{20'h00123, 1'b1, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h3F,7'h79,7'h24,7'h30}};
    vecs[2] = '{20'h00123, 1'b1, 1'b0, {7'h7F,7'h7F,7'h3F,7'h40,7'h40,7'h79,7'h24,7'h30}};
    vecs[3] = '{20'h00000, 1'b1, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}};
    vecs[4] = '{20'h00000, 1'b1, 1'b0, {7'h7F,7'h7F,7'h7F,7'h40,7'h40,7'h40,7'h40,7'h40}};
    vecs[5] = '{20'h99999, 1'b1, 1'b1, {7'h7F,7'h7F,7'h3F,7'h10,7'h10,7'h10,7'h10,7'h10}};
    vecs[6] = '{20'h000A7, 1'b0, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h06,7'h78}};
    vecs[7] = '{20'h000A7, 1'b1, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h3F,7'h06,7'h78}};
    vecs[8] = '{20'h40560, 1'b0, 1'b1, {7'h7F,7'h7F,7'h7F,7'h19,7'h40,7'h12,7'h02,7'h40}};
    vecs[9] = '{20'h00800, 1'b1, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h3F,7'h00,7'h40,7'h40}};

    reset           = 1'b1;
    bus.load        = 1'b0;
    bus.bcd         = '0;
    bus.is_negative = 1'b0;
    bus.blank_lz    = 1'b1;

    // Reset held three cycles, then first slot and a full scan with wrap
    repeat (3) tick();
    check("reset_an", 32'(bus.an_n), 32'hFF);
    check("reset_seg", 32'(bus.seg_n), 32'h7F);
    reset = 1'b0;
    tick();
    check("first_an", 32'(bus.an_n), 32'hFE);
    check("first_seg", 32'(bus.seg_n), 32'h40);
    repeat (35) tick();

    // Table of display patterns
    foreach (vecs[v]) begin
      bus.load        = 1'b1;
      bus.bcd         = vecs[v].bcd;
      bus.is_negative = vecs[v].neg;
      bus.blank_lz    = vecs[v].blz;
      tick();
      bus.load = 1'b0;
      tbl_segs = vecs[v].segs;
      tbl_on   = 1'b1;
      repeat (32) tick();
      tbl_on = 1'b0;
    end

    // Reset and load together: reset wins
    reset           = 1'b1;
    bus.load        = 1'b1;
    bus.bcd         = 20'h99999;
    bus.is_negative = 1'b1;
    bus.blank_lz    = 1'b1;
    repeat (2) tick();
    reset    = 1'b0;
    bus.load = 1'b0;
    tick();
    check("rst_over_load_an", 32'(bus.an_n), 32'hFE);
    check("rst_over_load_seg", 32'(bus.seg_n), 32'h40);
    repeat (8) tick();

    // Mid-slot load on slot 2
    bus.load        = 1'b1;
    bus.bcd         = 20'h00123;
    bus.is_negative = 1'b0;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 40 && (m_cnt % 32) != 9; i++) tick();
    check("midslot_sync", 32'(m_cnt % 32), 32'd9);
    bus.load = 1'b1;
    bus.bcd  = 20'h00456;
    tick();
    bus.load = 1'b0;
    check("midslot_old_seg", 32'(bus.seg_n), 32'h79);
    check("midslot_old_an", 32'(bus.an_n), 32'hFB);
    tick();
    check("midslot_new_seg", 32'(bus.seg_n), 32'h19);
    check("midslot_new_an", 32'(bus.an_n), 32'hFB);
    tick();
    check("midslot_hold_an", 32'(bus.an_n), 32'hFB);
    tick();
    check("midslot_end_an", 32'(bus.an_n), 32'hF7);
    check("midslot_end_seg", 32'(bus.seg_n), 32'h7F);
    repeat (30) tick();

    // Randomized loads against the reference model
    repeat (600) begin
      bus.load = ($urandom_range(0, 5) == 0);
      begin
        int nlen;
        nlen = $urandom_range(0, BD);
        for (int i = 0; i < BD; i++) begin
          if (i < nlen) bus.bcd[i*4 +: 4] = 4'($urandom_range(0, 9));
          else          bus.bcd[i*4 +: 4] = 4'd0;
          if ($urandom_range(0, 15) == 0) bus.bcd[i*4 +: 4] = 4'($urandom_range(10, 15));
        end
      end
      bus.is_negative = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 23) == 0) bus.blank_lz = ~bus.blank_lz;
      tick();
    end
    bus.load = 1'b0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
